// File: rtl/spi_master_sched.sv
// SPI master shared by a framed-word burst requester (A) and an out-of-band byte requester (B).
// Round-robin arbitration in IDLE; LSB-first, little-endian transfers with a fixed post-transaction gap.
module spi_master_sched #(
  parameter int unsigned HALF_DIV = 4,
  parameter int unsigned LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [LEN_W-1:0] a_len,
  input  logic [31:0]      a_wdata,
  output logic             a_wnext,
  output logic [31:0]      a_rdata,
  output logic             a_rvalid,
  output logic             a_done,
  input  logic             b_req,
  input  logic [7:0]       b_byte,
  output logic [7:0]       b_rdata,
  output logic             b_done,
  output logic             spi_clk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs,
  output logic             spi_frame,
  output logic             busy
);

  localparam int unsigned CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, FSETUP, CSETUP, BIT_LO, BIT_HI, BYTE_END, HOLD, GAP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             expired;
  logic [31:0]      tx;
  logic [31:0]      rx;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] word_cnt;
  logic [2:0]       bit_cnt;
  logic [1:0]       byte_cnt;
  logic             sel_b;
  logic             last_b;

  assign expired = (cnt == '0);

  // Single-process controller; every state wait is HALF_DIV cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      len       <= '0;
      word_cnt  <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      sel_b     <= 1'b0;
      last_b    <= 1'b1;
      a_wnext   <= 1'b0;
      a_rdata   <= '0;
      a_rvalid  <= 1'b0;
      a_done    <= 1'b0;
      b_rdata   <= '0;
      b_done    <= 1'b0;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_cs    <= 1'b1;
      spi_frame <= 1'b1;
      busy      <= 1'b0;
    end else begin
      a_wnext  <= 1'b0;
      a_rvalid <= 1'b0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
      if (!expired) cnt <= cnt - 1'b1;

      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          byte_cnt <= '0;
          word_cnt <= '0;
          if (a_req && (!b_req || last_b)) begin
            sel_b     <= 1'b0;
            last_b    <= 1'b0;
            len       <= a_len;
            tx        <= a_wdata;
            a_wnext   <= 1'b1;
            spi_frame <= 1'b0;
            busy      <= 1'b1;
            cnt       <= CNT_LOAD;
            state     <= FSETUP;
          end else if (b_req) begin
            sel_b  <= 1'b1;
            last_b <= 1'b1;
            tx     <= {24'd0, b_byte};
            spi_cs <= 1'b0;
            busy   <= 1'b1;
            cnt    <= CNT_LOAD;
            state  <= CSETUP;
          end
        end
        FSETUP: if (expired) begin
          spi_cs <= 1'b0;
          cnt    <= CNT_LOAD;
          state  <= CSETUP;
        end
        CSETUP: if (expired) begin
          spi_mosi <= tx[0];
          tx       <= tx >> 1;
          cnt      <= CNT_LOAD;
          state    <= BIT_LO;
        end
        BIT_LO: if (expired) begin
          spi_clk <= 1'b1;
          rx      <= {spi_miso, rx[31:1]};
          cnt     <= CNT_LOAD;
          state   <= (bit_cnt == 3'd7) ? BYTE_END : BIT_HI;
        end
        BIT_HI: if (expired) begin
          spi_clk  <= 1'b0;
          bit_cnt  <= bit_cnt + 1'b1;
          spi_mosi <= tx[0];
          tx       <= tx >> 1;
          cnt      <= CNT_LOAD;
          state    <= BIT_LO;
        end
        // High phase of a byte's last bit; byte/word bookkeeping happens on exit
        BYTE_END: if (expired) begin
          spi_clk <= 1'b0;
          bit_cnt <= '0;
          cnt     <= CNT_LOAD;
          if (sel_b) begin
            state <= HOLD;
          end else if (byte_cnt != 2'd3) begin
            byte_cnt <= byte_cnt + 1'b1;
            spi_mosi <= tx[0];
            tx       <= tx >> 1;
            state    <= BIT_LO;
          end else begin
            byte_cnt <= '0;
            a_rdata  <= rx;
            a_rvalid <= 1'b1;
            if (word_cnt != len) begin
              word_cnt <= word_cnt + 1'b1;
              a_wnext  <= 1'b1;
              spi_mosi <= a_wdata[0];
              tx       <= {1'b0, a_wdata[31:1]};
              state    <= BIT_LO;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: if (expired) begin
          spi_cs    <= 1'b1;
          spi_frame <= 1'b1;
          if (sel_b) begin
            b_done  <= 1'b1;
            b_rdata <= rx[31:24];
          end else begin
            a_done <= 1'b1;
          end
          cnt   <= CNT_LOAD;
          state <= GAP;
        end
        GAP: if (expired) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// Bench for spi_master_sched: table vectors, hand-written corner sequences and
// randomized transactions checked against a transaction-level reference model.
module tb_spi_master_sched;

  localparam int HD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req;
  logic [3:0]  a_len;
  logic [31:0] a_wdata;
  logic        a_wnext;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic        a_done;
  logic        b_req;
  logic [7:0]  b_byte;
  logic [7:0]  b_rdata;
  logic        b_done;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs;
  logic        spi_frame;
  logic        busy;

  spi_master_sched #(.HALF_DIV(HD), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_len(a_len), .a_wdata(a_wdata), .a_wnext(a_wnext),
    .a_rdata(a_rdata), .a_rvalid(a_rvalid), .a_done(a_done),
    .b_req(b_req), .b_byte(b_byte), .b_rdata(b_rdata), .b_done(b_done),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .spi_cs(spi_cs), .spi_frame(spi_frame), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0] tx_words    [16];
  logic [31:0] slave_words [16];
  logic [31:0] exp_rx      [16];
  logic        loopback = 1'b1;
  logic        mon_clr  = 1'b0;

  // Monitor state, sampled on the falling edge
  int          rise_cnt, cs_low_cnt, frame_low_cnt, wnext_cnt, a_done_cnt, b_done_cnt;
  logic [511:0] mosi_cap;
  logic [31:0] rv_q [$];
  logic [7:0]  b_rd;
  logic        prev_sclk;
  int          kinds [$];
  int          runs  [$];

  // Requester presents word k after k a_wnext pulses; slave returns bit n of its stream on rise n
  assign a_wdata  = tx_words[wnext_cnt[3:0]];
  assign spi_miso = loopback ? spi_mosi : slave_words[rise_cnt[8:5]][rise_cnt[4:0]];

  always @(negedge clk) begin
    if (mon_clr) begin
      rise_cnt      <= 0;
      cs_low_cnt    <= 0;
      frame_low_cnt <= 0;
      wnext_cnt     <= 0;
      a_done_cnt    <= 0;
      b_done_cnt    <= 0;
      mosi_cap      <= '0;
      b_rd          <= '0;
      rv_q.delete();
    end else begin
      if (spi_clk && !prev_sclk) begin
        if (rise_cnt < 512) mosi_cap[rise_cnt] <= spi_mosi;
        rise_cnt <= rise_cnt + 1;
      end
      if (!spi_cs)    cs_low_cnt    <= cs_low_cnt + 1;
      if (!spi_frame) frame_low_cnt <= frame_low_cnt + 1;
      if (a_wnext)    wnext_cnt     <= wnext_cnt + 1;
      if (a_rvalid)   rv_q.push_back(a_rdata);
      if (a_done)     a_done_cnt    <= a_done_cnt + 1;
      if (b_done) begin
        b_done_cnt <= b_done_cnt + 1;
        b_rd       <= b_rdata;
      end
    end
    prev_sclk <= spi_clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_spi_clk"},   32'(spi_clk),   32'd0);
    chk({tag, "_mosi"},      32'(spi_mosi),  32'd0);
    chk({tag, "_cs"},        32'(spi_cs),    32'd1);
    chk({tag, "_frame"},     32'(spi_frame), 32'd1);
    chk({tag, "_pulses"},    32'({a_wnext, a_rvalid, a_done, b_done}), 32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_a_rdata"},   a_rdata,        32'd0);
    chk({tag, "_b_rdata"},   32'(b_rdata),   32'd0);
  endtask

  task automatic start_txn(input bit is_b, input logic [3:0] len);
    @(posedge clk); #1; mon_clr = 1'b1;
    @(posedge clk); #1; mon_clr = 1'b0;
    a_len  = len;
    b_byte = tx_words[0][7:0];
    if (is_b) b_req = 1'b1; else a_req = 1'b1;
  endtask

  task automatic finish_txn(input string tag, input bit is_b, input int len, input int drop_at);
    int bits;
    bit seen;
    bits = is_b ? 8 : 32 * (len + 1);
    seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      @(posedge clk); #1;
      if (drop_at > 0 && c == drop_at) b_req = 1'b0;
      if ((is_b && b_done) || (!is_b && a_done)) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    a_req = 1'b0;
    b_req = 1'b0;
    for (int c = 0; c < 100 && busy; c++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk({tag, "_rises"},  32'(rise_cnt),   32'(bits));
    chk({tag, "_cs_low"}, 32'(cs_low_cnt), 32'(HD * (2 + 2 * bits)));
    chk({tag, "_frame"},  32'(frame_low_cnt), is_b ? 32'd0 : 32'(HD * (2 + 2 * bits) + HD));
    chk({tag, "_a_done"}, 32'(a_done_cnt), is_b ? 32'd0 : 32'd1);
    chk({tag, "_b_done"}, 32'(b_done_cnt), is_b ? 32'd1 : 32'd0);
    if (is_b) begin
      chk({tag, "_mosi"},    32'(mosi_cap[7:0]), 32'(tx_words[0][7:0]));
      chk({tag, "_b_rdata"}, 32'(b_rd),          32'(exp_rx[0][7:0]));
    end else begin
      chk({tag, "_wnext"},  32'(wnext_cnt),   32'(len + 1));
      chk({tag, "_rvalid"}, 32'(rv_q.size()), 32'(len + 1));
      for (int i = 0; i <= len; i++) begin
        chk({tag, "_mosi_word"}, mosi_cap[i*32 +: 32], tx_words[i]);
        if (i < rv_q.size()) chk({tag, "_rdata"}, rv_q[i], exp_rx[i]);
      end
    end
  endtask

  typedef struct {
    bit          is_b;
    logic [3:0]  len;
    bit          lb;
    logic [31:0] w0, w1, s0, s1;
    logic [31:0] rd0, rd1;
  } vec_t;

  vec_t vecs [5];
  bit          r_is_b;
  int          r_len;

  initial begin
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; a_len = '0; b_byte = '0;
    for (int i = 0; i < 16; i++) begin tx_words[i] = '0; slave_words[i] = '0; exp_rx[i] = '0; end
    vecs[0] = '{1'b1, 4'd0, 1'b1, 32'h000000A5, 32'h0, 32'h0, 32'h0, 32'h000000A5, 32'h0};
    vecs[1] = '{1'b0, 4'd1, 1'b0, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF, 32'h00000001,
                32'hDEADBEEF, 32'h00000001};
    vecs[2] = '{1'b0, 4'd0, 1'b1, 32'h80000001, 32'h0, 32'h0, 32'h0, 32'h80000001, 32'h0};
    vecs[3] = '{1'b1, 4'd0, 1'b0, 32'h0000003C, 32'h0, 32'h000000C3, 32'h0, 32'h000000C3, 32'h0};
    vecs[4] = '{1'b1, 4'd0, 1'b1, 32'h00000000, 32'h0, 32'hFFFFFFFF, 32'h0, 32'h00000000, 32'h0};

    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_checks("reset");
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      tx_words[0] = vecs[v].w0; tx_words[1] = vecs[v].w1;
      slave_words[0] = vecs[v].s0; slave_words[1] = vecs[v].s1;
      exp_rx[0] = vecs[v].rd0; exp_rx[1] = vecs[v].rd1;
      loopback = vecs[v].lb;
      start_txn(vecs[v].is_b, vecs[v].len);
      finish_txn($sformatf("vec%0d", v), vecs[v].is_b, int'(vecs[v].len), 0);
    end

    // B request withdrawn shortly after grant still completes
    tx_words[0] = 32'h5A; exp_rx[0] = 32'h5A; loopback = 1'b1;
    start_txn(1'b1, 4'd0);
    finish_txn("b_drop", 1'b1, 0, 3);

    // Maximum burst length
    for (int i = 0; i < 16; i++) begin
      tx_words[i] = $urandom; slave_words[i] = $urandom; exp_rx[i] = slave_words[i];
    end
    loopback = 1'b0;
    start_txn(1'b0, 4'd15);
    finish_txn("len15", 1'b0, 15, 0);

    // Reset during the third byte of a word aborts; held request restarts from byte 0
    tx_words[0] = 32'hA1B2C3D4; slave_words[0] = 32'h0F1E2D3C; exp_rx[0] = slave_words[0];
    start_txn(1'b0, 4'd0);
    for (int c = 0; c < 500 && rise_cnt < 20; c++) begin @(posedge clk); #1; end
    chk("abort_reached_byte2", 32'(rise_cnt >= 20), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    reset_checks("abort");
    chk("abort_no_done", 32'(a_done_cnt), 32'd0);
    rst = 1'b0; mon_clr = 1'b1;
    @(posedge clk); #1; mon_clr = 1'b0;
    finish_txn("restart", 1'b0, 0, 0);

    // Both requesters held together after reset alternate, A first
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; loopback = 1'b1; a_len = 4'd0; b_byte = 8'h3C;
    a_req = 1'b1; b_req = 1'b1;
    begin
      int run;
      run = 0;
      for (int c = 0; c < 3000 && kinds.size() < 4; c++) begin
        @(posedge clk); #1;
        if (a_done) kinds.push_back(0);
        if (b_done) kinds.push_back(1);
        if (spi_cs) run++;
        else if (run > 0) begin runs.push_back(run); run = 0; end
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("arb_count", 32'(kinds.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < kinds.size()) chk($sformatf("arb_order%0d", i), 32'(kinds[i]), 32'(i % 2));
    for (int i = 1; i < 4; i++)
      if (i < runs.size()) chk($sformatf("arb_gap%0d", i), 32'(runs[i]), 32'(HD + 1 + ((i % 2 == 0) ? HD : 0)));
    for (int c = 0; c < 100 && busy; c++) begin @(posedge clk); #1; end

    // Randomized transactions against the transaction-level model
    for (int k = 0; k < 10; k++) begin
      r_is_b   = 1'($urandom_range(0, 1));
      r_len    = int'($urandom_range(0, 3));
      loopback = 1'($urandom_range(0, 1));
      for (int i = 0; i < 16; i++) begin
        tx_words[i]    = $urandom;
        slave_words[i] = $urandom;
        exp_rx[i]      = loopback ? tx_words[i] : slave_words[i];
      end
      start_txn(r_is_b, 4'(r_len));
      finish_txn($sformatf("rnd%0d", k), r_is_b, r_is_b ? 0 : r_len, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_master_sched.md
SPI_MASTER_SCHED -- requirements
Module: spi_master_sched

Interface
REQ-001 SHALL have parameter HALF_DIV, default 4: clk cycles per SPI half-period, legal range 1 or more.
REQ-002 SHALL have parameter LEN_W, default 4: width of the word-burst length field.
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 a_req  in  1  framed-word requester: request, held high until a_done.
REQ-006 a_len  in  LEN_W  words in burst minus 1; latched at grant.
REQ-007 a_wdata  in  32  next word to send; valid while a_req is high.
REQ-008 a_wnext  out  1  one-cycle pulse: a_wdata latched, requester advances.
REQ-009 a_rdata  out  32  received word; valid when a_rvalid is high.
REQ-010 a_rvalid  out  1  one-cycle pulse per received word.
REQ-011 a_done  out  1  one-cycle pulse when a burst completes.
REQ-012 b_req  in  1  OOB-byte requester: request, held high until b_done.
REQ-013 b_byte  in  8  OOB byte to send; latched at grant.
REQ-014 b_rdata  out  8  received OOB byte; valid with b_done.
REQ-015 b_done  out  1  one-cycle pulse when the OOB byte completes.
REQ-016 spi_clk  out  1  SPI clock, idle low.
REQ-017 spi_mosi  out  1  SPI data out.
REQ-018 spi_miso  in  1  SPI data in.
REQ-019 spi_cs  out  1  chip select, active low.
REQ-020 spi_frame  out  1  word-frame marker, active low; low only for A bursts.
REQ-021 busy  out  1  high from grant until the post-transaction gap ends.

Function
REQ-022 States SHALL be IDLE, FSETUP, CSETUP, BIT_LO, BIT_HI, BYTE_END, HOLD, GAP; each timed wait SHALL last HALF_DIV clk cycles.
REQ-023 IDLE SHALL grant when any request is high; both high: grant the requester not served last; first arbitration after reset grants A.
REQ-024 Grant to A SHALL: latch a_len, latch a_wdata, pulse a_wnext, drive spi_frame=0, then enter FSETUP (wait) and then CSETUP.
REQ-025 Grant to B SHALL latch b_byte and enter CSETUP directly; spi_frame SHALL stay 1.
REQ-026 CSETUP SHALL drive spi_cs=0 and wait before the first bit.
REQ-027 Per bit: BIT_LO SHALL drive spi_mosi = current LSB with spi_clk=0 and wait; BIT_HI SHALL drive spi_clk=1, sample spi_miso on entry into bit 7 of the shift-in register (LSB-first), and wait.
REQ-028 Byte order SHALL be little-endian (word bits 7:0 first); bit order SHALL be LSB first; receive order SHALL be mirrored.
REQ-029 After the 4th byte of a word, a_rdata SHALL update and a_rvalid SHALL pulse on the next cycle; if words remain, the next a_wdata SHALL be latched with an a_wnext pulse in that same cycle, with no gap on spi_clk beyond one BIT_LO.
REQ-030 After the last bit (word count = a_len+1 for A, 1 byte for B), HOLD SHALL keep spi_cs low and spi_clk low for one wait, then set spi_cs=1, spi_frame=1, and pulse a_done or b_done with b_rdata valid.
REQ-031 GAP SHALL hold cs/frame high for one wait before returning to IDLE; a request held high across GAP SHALL be re-arbitrated in IDLE.
REQ-032 Requests dropping mid-transaction SHALL be ignored; a transaction always runs to completion.
REQ-033 spi_cs low duration SHALL equal HALF_DIV*(2 + 2*bits), with bits = 8 (B) or 32*(a_len+1) (A).
REQ-034 Bit, byte and word counters SHALL never wrap mid-transaction; a_len at its maximum value SHALL send 2^LEN_W words.

Reset
REQ-035 With rst high at a clk edge, outputs SHALL be: spi_clk=0, spi_mosi=0, spi_cs=1, spi_frame=1, a_wnext, a_rvalid, a_done, b_done and busy=0; a_rdata and b_rdata=0; state IDLE; last-served=B.
REQ-036 Reset mid-transaction SHALL abort with no done pulse; the requester re-requests by keeping req high.

Verification (HALF_DIV=2, LEN_W=4)
REQ-037 B only, b_byte=0xA5, miso=mosi loopback -> mosi bits 1,0,1,0,0,1,0,1; b_rdata=0xA5; spi_cs low 36 clk cycles; spi_frame stays 1; b_done one pulse.
REQ-038 A only, a_len=1, words 0x12345678 and 0xCAFEBABE; slave returns 0xDEADBEEF and 0x00000001 -> first mosi byte 0x78; 64 spi_clk rising edges; a_rvalid pulses with 0xDEADBEEF then 0x00000001; 2 a_wnext pulses; spi_frame falls 2 cycles before spi_cs.
REQ-039 a_req and b_req rise together after reset, both held -> order A, B, A, B; each grant is preceded by a GAP of 2 cycles with spi_cs high.
REQ-040 rst pulsed during byte 2 of an A word -> next edge gives all outputs at REQ-035 values and no a_done; with a_req still high, the burst restarts from byte 0.
REQ-041 a_len=15 -> exactly 16 a_wnext and 16 a_rvalid pulses; 512 spi_clk edges; one a_done.
REQ-042 b_req dropped 3 cycles after grant -> the byte still completes and b_done pulses.
